// File: rtl/qif_synapse.sv
// qif_synapse: event FIFO feeding a saturating, periodically decaying synaptic current accumulator.
module qif_synapse #(
  parameter logic signed [7:0] W0 = 8'sd40,
  parameter logic signed [7:0] W1 = 8'sd20,
  parameter logic signed [7:0] W2 = -8'sd20,
  parameter logic signed [7:0] W3 = -8'sd40,
  parameter int unsigned DECAY_SHIFT = 3,
  parameter int unsigned DECAY_PERIOD = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spike_valid,
  input  logic [1:0]        spike_idx,
  input  logic              freeze,
  output logic              spike_ready,
  output logic signed [7:0] I_syn,
  output logic [2:0]        fifo_count
);
  logic [1:0] mem_q [4];
  logic [1:0] wr_q, rd_q;
  logic [2:0] cnt_q, cnt_d;
  logic [9:0] pre_q, pre_d;
  logic signed [9:0] acc_q, acc_d, sh;
  logic signed [7:0] isyn_q, isyn_d, w;
  logic signed [11:0] dec, sum;
  logic push, pop, tick;
  assign spike_ready = !rst_n && cnt_q < 3'd4;
  assign I_syn = isyn_q;
  assign fifo_count = cnt_q;
  always_comb begin
    push = spike_valid && spike_ready;
    pop = !freeze && cnt_q != 3'd0;
    tick = !freeze && pre_q == 10'(DECAY_PERIOD - 1);
    cnt_d = cnt_q + 3'(push) - 3'(pop);
    pre_d = freeze ? pre_q : tick ? 10'd0 : pre_q + 10'd1;
    w = mem_q[rd_q] == 2'd0 ? W0 : mem_q[rd_q] == 2'd1 ? W1 : mem_q[rd_q] == 2'd2 ? W2 : W3;
    sh = acc_q >>> DECAY_SHIFT;
    // positive values always decay by at least one so they cannot stall above zero
    dec = !tick ? 12'sd0 : (acc_q > 10'sd0 && sh == 10'sd0) ? 12'sd1 : {{2{sh[9]}}, sh};
    sum = {{2{acc_q[9]}}, acc_q} - dec + (pop ? {{4{w[7]}}, w} : 12'sd0);
    acc_d = sum > 12'sd511 ? 10'sd511 : sum < -12'sd512 ? 10'sh200 : sum[9:0];
    isyn_d = freeze ? isyn_q : acc_q > 10'sd127 ? 8'sd127 : acc_q < -10'sd128 ? 8'sh80 : acc_q[7:0];
  end
  always_ff @(posedge clk) begin
    if (rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      pre_q <= '0;
      acc_q <= '0;
      isyn_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= spike_idx;
        wr_q <= wr_q + 2'd1;
      end
      if (pop) rd_q <= rd_q + 2'd1;
      cnt_q <= cnt_d;
      pre_q <= pre_d;
      acc_q <= acc_d;
      isyn_q <= isyn_d;
    end
  end
endmodule

// File: tb/tb_qif_synapse.sv
// tb_qif_synapse: slow (no decay) and fast (decaying) instances checked against a queue-based model.
module tb_qif_synapse;
  logic clk = 0, rst_n = 1, spike_valid = 0, freeze = 0;
  logic [1:0] spike_idx = 0;
  logic rdy_s, rdy_f;
  logic signed [7:0] isyn_s, isyn_f;
  logic [2:0] cnt_s, cnt_f;
  qif_synapse #(.DECAY_PERIOD(1000)) u_slow (.clk(clk), .rst_n(rst_n), .spike_valid(spike_valid),
    .spike_idx(spike_idx), .freeze(freeze), .spike_ready(rdy_s), .I_syn(isyn_s), .fifo_count(cnt_s));
  qif_synapse u_fast (.clk(clk), .rst_n(rst_n), .spike_valid(spike_valid),
    .spike_idx(spike_idx), .freeze(freeze), .spike_ready(rdy_f), .I_syn(isyn_f), .fifo_count(cnt_f));
  always #5 clk = ~clk;
  int n_vec = 0, n_bad = 0;
  int q[$];
  int acc[2], pre[2], isyn[2];
  int per[2] = '{1000, 4};
  int wt[4] = '{40, 20, -20, -40};
  typedef struct {bit v; bit [1:0] idx; bit f; bit r; int cnt; int isyn;} vec_t;
  vec_t tbl[7];
  function automatic int sat(int v, int lo, int hi);
    return v < lo ? lo : v > hi ? hi : v;
  endfunction
  task automatic chk(string nm, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic cyc(bit v, bit [1:0] idx, bit f, bit r);
    int w, d;
    bit push, pop, tick;
    spike_valid = v; spike_idx = idx; freeze = f; rst_n = r;
    #1;
    chk("ready_slow", int'(rdy_s), int'(!r && q.size() < 4));
    chk("ready_fast", int'(rdy_f), int'(!r && q.size() < 4));
    if (r) begin
      q.delete();
      for (int k = 0; k < 2; k++) begin acc[k] = 0; pre[k] = 0; isyn[k] = 0; end
    end else begin
      push = v && q.size() < 4;
      pop = !f && q.size() > 0;
      w = pop ? wt[q[0]] : 0;
      for (int k = 0; k < 2; k++) begin
        tick = !f && pre[k] == per[k] - 1;
        d = acc[k] >>> 3;
        if (acc[k] > 0 && d == 0) d = 1;
        if (!f) isyn[k] = sat(acc[k], -128, 127);
        acc[k] = sat(acc[k] - (tick ? d : 0) + w, -512, 511);
        if (!f) pre[k] = tick ? 0 : pre[k] + 1;
      end
      if (pop) void'(q.pop_front());
      if (push) q.push_back(int'(idx));
    end
    @(posedge clk);
    #1;
    chk("isyn_slow", int'(isyn_s), isyn[0]);
    chk("isyn_fast", int'(isyn_f), isyn[1]);
    chk("count_slow", int'(cnt_s), q.size());
    chk("count_fast", int'(cnt_f), q.size());
  endtask
  initial begin
    tbl[0] = '{0, 0, 0, 1, 0, 0};
    tbl[1] = '{1, 0, 0, 0, 1, 0};
    tbl[2] = '{0, 0, 0, 0, 0, 0};
    tbl[3] = '{1, 3, 0, 0, 1, 40};
    tbl[4] = '{0, 0, 0, 0, 0, 40};
    tbl[5] = '{0, 0, 0, 0, 0, 0};
    tbl[6] = '{0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 7; i++) begin
      cyc(tbl[i].v, tbl[i].idx, tbl[i].f, tbl[i].r);
      chk("tbl_count", int'(cnt_s), tbl[i].cnt);
      chk("tbl_isyn", int'(isyn_s), tbl[i].isyn);
    end
    for (int i = 0; i < 5; i++) cyc(1, 2'(i), 1, 0);
    chk("bp_full", int'(cnt_s), 4);
    chk("bp_ready", int'(rdy_s), 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0);
    for (int i = 0; i < 14; i++) cyc(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
    chk("sat_hi", int'(isyn_s), 127);
    cyc(1, 3, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
    chk("sat_471", int'(isyn_s), 127);
    for (int i = 0; i < 20; i++) cyc(1, 3, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
    chk("sat_lo", int'(isyn_s), -128);
    for (int i = 0; i < 10; i++) cyc(0, 0, 1, 0);
    for (int i = 0; i < 300; i++) cyc(0, 0, 0, 0);
    chk("decay_zero", int'(isyn_f), 0);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 1, 1, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    chk("rst_count", int'(cnt_s), 0);
    chk("rst_isyn", int'(isyn_s), 0);
    rst_n = 0;
    #1;
    chk("rst_ready", int'(rdy_s), 1);
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)), $urandom_range(0, 9) < 3, $urandom_range(0, 199) == 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/qif_synapse.md
QIF_SYNAPSE -- requirements
Module: qif_synapse

Interface
REQ-001 Parameter W0, default 8'sd40: signed weight applied for spike_idx=0.
REQ-002 Parameter W1, default 8'sd20: signed weight for spike_idx=1.
REQ-003 Parameter W2, default -8'sd20: signed weight for spike_idx=2.
REQ-004 Parameter W3, default -8'sd40: signed weight for spike_idx=3.
REQ-005 Parameter DECAY_SHIFT, default 3, legal range 1..6: decay divisor exponent.
REQ-006 Parameter DECAY_PERIOD, default 4, legal range 1..1023: cycles between decay steps.
REQ-007 clk  input  1  the single clock; all state updates on its rising edge.
REQ-008 rst_n  input  1  synchronous reset, active-high (asserted = 1), sampled on rising clk.
REQ-009 spike_valid  input  1  upstream presents a spike event.
REQ-010 spike_idx  input  2  synapse index of the presented event.
REQ-011 freeze  input  1  downstream stall; halts event application and decay.
REQ-012 spike_ready  output  1  event FIFO can accept this cycle.
REQ-013 I_syn  output  8  signed synaptic current that feeds the QIF neuron I_syn input.
REQ-014 fifo_count  output  3  events held in the FIFO, 0..4.

Function
REQ-015 The block SHALL hold a 4-entry event FIFO of 2-bit indices; an event is accepted on a rising edge where spike_valid=1 and spike_ready=1.
REQ-016 spike_ready SHALL equal (fifo_count<4) and not rst_n, derived from registered state only; no push when full even if a pop occurs the same cycle.
REQ-017 fifo_count SHALL be +1 on push only, -1 on pop only, unchanged on push+pop.
REQ-018 When freeze=0 and FIFO non-empty, one event SHALL be popped per cycle and its weight added to accumulator acc; no bypass when empty.
REQ-019 acc SHALL be a 10-bit signed register saturating to [-512, 511].
REQ-020 A prescaler SHALL count 0..DECAY_PERIOD-1, advancing only when freeze=0; a decay tick occurs on the cycle the count equals DECAY_PERIOD-1, and the count wraps to 0.
REQ-021 On a tick, d = acc >>> DECAY_SHIFT (arithmetic); if acc>0 and d=0 then d=1; decay term is -d.
REQ-022 Next acc SHALL be sat10(acc - d_if_tick + w_if_pop), computed at full width before saturation, decay using the pre-update acc.
REQ-023 I_syn SHALL be a register loaded each cycle with acc clamped to [-128, 127] when freeze=0; it holds when freeze=1.
REQ-024 Latency: event accepted at edge N, applied to acc at edge N+1, visible on I_syn after edge N+2 (FIFO empty, freeze=0).
REQ-025 freeze=1 SHALL still allow pushes until full; FIFO order SHALL be strictly first-in first-out.

Reset
REQ-026 While rst_n=1: FIFO pointers, fifo_count, acc, prescaler and I_syn SHALL be 0, spike_ready SHALL be 0.
REQ-027 Reset mid-operation SHALL discard all queued events; spike_ready=1 from the first cycle after release.

Verification
REQ-028 Reset: rst_n=1 two cycles with FIFO holding 3 events -> fifo_count=0, I_syn=0, spike_ready=0 during, 1 the cycle after.
REQ-029 Single event (DECAY_PERIOD=1000): idx0 accepted edge N -> I_syn=40 after edge N+2; idx3 next -> I_syn=0.
REQ-030 Saturation (DECAY_PERIOD=1000): 14 back-to-back idx0 -> acc=511, I_syn=127; then one idx3 -> acc=471, I_syn=127; I_syn reaches -128 only after acc <= -128.
REQ-031 Backpressure: freeze=1, spike_valid=1 five cycles -> 4 accepted, fifo_count=4, spike_ready=0 on 5th; freeze=0 -> drains one per cycle, I_syn follows in push order.
REQ-032 Decay (DECAY_PERIOD=4, DECAY_SHIFT=3): acc=40 -> successive ticks 35, 31, 28, ... reaching 0 (minimum step 1); acc=-8 -> -7, ... -> 0; tick coinciding with idx1 pop at acc=40 -> 55.
REQ-033 Freeze mid-run: freeze=1 for 10 cycles -> acc, I_syn and prescaler unchanged; resume continues tick phase exactly.
